add_seq_64: RTL and testbench
=============================

# add_seq_64

Multi-cycle 64-bit add/subtract sequencer that time-shares a single 16-bit carry-select slice adder over four consecutive cycles, least significant slice first. It has a valid/ready request channel and a valid/ready result channel. It sits between an operand issuer and the result consumer wherever a full-width csa_64 costs too much area and a 4-cycle latency is acceptable.

## Interface
- SLICE_W, 16, width of the shared slice adder; fixed to 16 by csa_16.
- N_SLICES, 4, slices per operation; SLICE_W*N_SLICES = 64.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  request present.
- in_ready  output  1  block can accept a request; high only in IDLE with rst low.
- in_a  input  64  operand A.
- in_b  input  64  operand B.
- in_cin  input  1  carry-in; used only when in_sub=0.
- in_sub  input  1  1: A - B; 0: A + B + cin.
- out_valid  output  1  result held and valid.
- out_ready  input  1  consumer takes the result.
- out_sum  output  64  result.
- out_cout  output  1  carry out of bit 63. For subtract this is the no-borrow flag.
- out_ovf  output  1  two's-complement signed overflow.

## Operation
- FSM states: IDLE, CALC, DONE. Registers: a_reg, b_reg (B or ~B), carry_reg, cnt (2 bits), sum_reg, cout_reg, ovf_reg.
- IDLE: in_ready=1. When in_valid=1 (accept):
  - a_reg <= in_a.
  - b_reg <= in_sub ? ~in_b : in_b.
  - carry_reg <= in_sub ? 1 : in_cin.
  - cnt <= 0; next state CALC.
  - When in_valid=0, stay in IDLE.
- CALC, each cycle:
  - The slice adder gets a_reg[cnt*16+:16], b_reg[cnt*16+:16] and carry_reg.
  - sum_reg[cnt*16+:16] <= slice sum; carry_reg <= slice carry-out.
  - When cnt=3: cout_reg <= slice carry-out, ovf_reg <= (a_reg[63]==b_reg[63]) && (slice sum[15] != a_reg[63]); next state DONE. Otherwise cnt <= cnt+1.
- DONE:
  - out_valid=1; out_sum, out_cout and out_ovf are held stable.
  - When out_ready=1, next state IDLE. Otherwise stay in DONE with outputs unchanged.
- Arithmetic is modulo 2^64. The result is bit-exact to {cout,sum} = a + b_eff + cin_eff, where b_eff and cin_eff are the values loaded into b_reg and carry_reg at accept.
- in_cin is ignored when in_sub=1.
- Inputs are sampled only on the accept edge. Later changes to in_* have no effect on the operation in flight.
- in_valid while not in IDLE: no effect, and the request is not lost. The requester must hold it until in_ready.
- out_sum, out_cout and out_ovf are undefined-but-stable whenever out_valid=0. Benches check them only when out_valid=1.

## Timing
- Reset: while rst=1, in_ready=0. On the first edge with rst=1: state=IDLE; out_valid, out_sum, out_cout, out_ovf, cnt and carry_reg all 0. in_ready=1 from the cycle after rst deasserts.
- Reset mid-operation (CALC or DONE): the operation is aborted and no out_valid is produced. The block is back in IDLE after one rst edge.
- Latency: accept at edge T; slices computed at edges T+1..T+4; out_valid=1 from edge T+4.
- Throughput with out_ready held high: DONE lasts 1 cycle (leaves at T+5), IDLE accepts at T+6. Minimum issue interval is 6 cycles.
- The out_valid=1 and out_ready=1 handshake completes on that edge. out_valid drops on the following cycle.
- in_ready is combinational from state and rst only. It never depends on in_valid.
- out_valid is a registered state decode.
- There is no combinational path from in_* or out_ready to any output.

## Structure
- Package add_seq_pkg:
  - state enum {IDLE, CALC, DONE};
  - constants SLICE_W=16, N_SLICES=4, DATA_W=64, CNT_W=2.
- One sub-module: the existing csa_16, instantiated once as the shared slice adder.
- Everything else (FSM, operand/result registers, overflow logic) is in add_seq_64.

## Test plan
- Reset, then A=0x0000_0000_0000_0001, B=0xFFFF_FFFF_FFFF_FFFF, sub=0, cin=0 -> out_valid at T+4, sum=0, cout=1, ovf=0. This exercises the carry ripple across all four slices.
- A=0x7FFF_FFFF_FFFF_FFFF, B=1, sub=0 -> sum=0x8000_0000_0000_0000, cout=0, ovf=1.
- Subtract: A=5, B=7, sub=1, cin=1 (cin ignored) -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0, ovf=0. Then A=7, B=5 -> sum=2, cout=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0 throughout. Toggle in_a/in_b during CALC -> the result matches the operands sampled at accept.
- Reset mid-op: rst=1 at T+2 -> no out_valid; in_ready=1 one cycle after rst drops. The next op (A=3, B=4) returns sum=7.
- Back-to-back random: 1000 ops with random in_valid/out_ready against a+b_eff+cin_eff. Check results, no loss or duplication, and 6-cycle issue interval when unthrottled.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared types and sizing for the time-shared 64-bit add/subtract sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package add_seq_pkg;

  localparam int SLICE_W  = 16;
  localparam int N_SLICES = 4;
  localparam int DATA_W   = SLICE_W * N_SLICES;
  localparam int CNT_W    = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/csa_16.sv
// 16-bit carry-select adder: low byte ripples, high byte precomputed for both carries.
// Latency: purely combinational.
// Backpressure: none (no handshake).
module csa_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] sum,
  output logic        cout
);

  logic [8:0] lo;
  logic [8:0] hi0;
  logic [8:0] hi1;

  assign lo  = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'd0, cin};
  // High byte computed for carry-in 0 and 1; the low-byte carry picks one.
  assign hi0 = {1'b0, a[15:8]} + {1'b0, b[15:8]};
  assign hi1 = hi0 + 9'd1;

  assign sum  = {(lo[8] ? hi1[7:0] : hi0[7:0]), lo[7:0]};
  assign cout = lo[8] ? hi1[8] : hi0[8];

endmodule

// File: rtl/add_seq_64.sv
// 64-bit add/subtract computed over four cycles on one shared 16-bit slice adder, LSB slice first.
// Latency: accept at edge T, out_valid from edge T+4; minimum issue interval 6 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
module add_seq_64
  import add_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic              in_cin,
  input  logic              in_sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_cout,
  output logic              out_ovf
);

  localparam int LSB_W = CNT_W + $clog2(SLICE_W);

  state_t              state;
  state_t              next_state;
  logic [DATA_W-1:0]   a_reg;
  logic [DATA_W-1:0]   b_reg;
  logic [DATA_W-1:0]   sum_reg;
  logic                carry_reg;
  logic                cout_reg;
  logic                ovf_reg;
  logic [CNT_W-1:0]    cnt;
  logic [LSB_W-1:0]    slice_lsb;
  logic [SLICE_W-1:0]  slice_a;
  logic [SLICE_W-1:0]  slice_b;
  logic [SLICE_W-1:0]  slice_sum;
  logic                slice_cout;
  logic                last_slice;

  // Bit offset of the slice being worked on: cnt * SLICE_W.
  assign slice_lsb  = {cnt, {($clog2(SLICE_W)){1'b0}}};
  assign slice_a    = a_reg[slice_lsb +: SLICE_W];
  assign slice_b    = b_reg[slice_lsb +: SLICE_W];
  assign last_slice = (cnt == CNT_W'(N_SLICES - 1));

  csa_16 u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state decode: accept in IDLE, four slice cycles, hold until consumed.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = CALC;
      CALC:    if (last_slice) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand capture on accept, one slice per CALC cycle, flags from the top slice.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
      cnt       <= '0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        a_reg     <= in_a;
        // Subtract as A + ~B + 1, so the adder itself never changes.
        b_reg     <= in_sub ? ~in_b : in_b;
        carry_reg <= in_sub ? 1'b1 : in_cin;
        cnt       <= '0;
      end
    end else if (state == CALC) begin
      sum_reg[slice_lsb +: SLICE_W] <= slice_sum;
      carry_reg                     <= slice_cout;
      if (last_slice) begin
        cout_reg <= slice_cout;
        // Like-signed operands whose sum changes sign overflowed.
        ovf_reg  <= (a_reg[DATA_W-1] == b_reg[DATA_W-1]) &&
                    (slice_sum[SLICE_W-1] != a_reg[DATA_W-1]);
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign out_sum   = sum_reg;
  assign out_cout  = cout_reg;
  assign out_ovf   = ovf_reg;

endmodule

// File: tb/tb_add_seq_64.sv
// Scoreboard bench for add_seq_64: driver pushes expected results, monitor pops on out_valid.
// Latency: checks out_valid exactly 4 cycles after accept and a 6-cycle issue interval unthrottled.
// Backpressure: monitor throttles out_ready (always, random, or held low 10 cycles).
module tb_add_seq_64;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  localparam logic signed [65:0] SMAX = 66'sh0_7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [65:0] SMIN = 66'sh3_8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_a;
  logic [63:0] in_b;
  logic        in_cin;
  logic        in_sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_sum;
  logic        out_cout;
  logic        out_ovf;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_issued = 0;
  int   n_recv = 0;
  int   cyc = 0;
  int   ready_mode = 0;   // 0: always ready, 1: random, 2: hold low 10 cycles
  int   last_acc = -1;
  bit   chk_interval = 1'b0;

  add_seq_64 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: full-width integer arithmetic; overflow from the true signed result range.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub);
    exp_t                    e;
    logic [63:0]             be;
    logic                    c;
    logic [64:0]             full;
    logic signed [65:0]      s;
    be     = sub ? ~b : b;
    c      = sub ? 1'b1 : cin;
    full   = {1'b0, a} + {1'b0, be} + {64'd0, c};
    s      = $signed({{2{a[63]}}, a}) + $signed({{2{be[63]}}, be}) + $signed({65'd0, c});
    e.sum  = full[63:0];
    e.cout = full[64];
    e.ovf  = (s > SMAX) || (s < SMIN);
    e.acc  = 0;
    return e;
  endfunction

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0:       v = 64'd0;
      1:       v = 64'hFFFF_FFFF_FFFF_FFFF;
      2:       v = 64'h7FFF_FFFF_FFFF_FFFF;
      3:       v = 64'h8000_0000_0000_0000;
      4:       v = {32'd0, 32'($urandom)};
      default: v = {32'($urandom), 32'($urandom)};
    endcase
    return v;
  endfunction

  // Called at a negedge. Holds the request until accepted, then scrambles the inputs.
  task automatic issue(input logic [63:0] a, input logic [63:0] b,
                       input logic cin, input logic sub, input exp_t e);
    int w = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("accept_in_ready", 64'(in_ready), 64'd1);
    if (in_ready) begin
      e.acc = cyc + 1;
      if (chk_interval && last_acc >= 0)
        chk("issue_interval", 64'(e.acc - last_acc), 64'd6);
      last_acc = e.acc;
      sb.push_back(e);
      n_issued++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = {32'($urandom), 32'($urandom)};
    in_b     = {32'($urandom), 32'($urandom)};
    in_cin   = 1'($urandom);
    in_sub   = 1'($urandom);
  endtask

  task automatic rand_issue();
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        sub;
    a   = rnd64();
    b   = rnd64();
    cin = 1'($urandom);
    sub = 1'($urandom);
    issue(a, b, cin, sub, model(a, b, cin, sub));
  endtask

  task automatic drain();
    int w = 0;
    while ((sb.size() != 0 || out_valid) && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("drain_within_bound", 64'(w < 200), 64'd1);
  endtask

  // Monitor: pops expectations when a result first appears, checks it stays put while stalled.
  initial begin : monitor
    exp_t cur;
    bit   have = 1'b0;
    int   held = 0;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        have      = 1'b0;
        held      = 0;
        out_ready = 1'b0;
      end else if (out_valid) begin
        if (!have) begin
          if (sb.size() == 0) begin
            chk("result_queue_depth", 64'(sb.size()), 64'd1);
            cur.sum  = out_sum;
            cur.cout = out_cout;
            cur.ovf  = out_ovf;
            cur.acc  = cyc;
          end else begin
            cur = sb.pop_front();
            n_recv++;
            chk("sum", out_sum, cur.sum);
            chk("cout", 64'(out_cout), 64'(cur.cout));
            chk("ovf", 64'(out_ovf), 64'(cur.ovf));
            chk("latency", 64'(cyc - cur.acc), 64'd4);
          end
          have = 1'b1;
          held = 0;
        end else begin
          chk("hold_sum", out_sum, cur.sum);
          chk("hold_cout", 64'(out_cout), 64'(cur.cout));
          chk("hold_ovf", 64'(out_ovf), 64'(cur.ovf));
          chk("in_ready_in_done", 64'(in_ready), 64'd0);
        end
        held++;
        case (ready_mode)
          0:       out_ready = 1'b1;
          1:       out_ready = 1'($urandom_range(0, 1));
          default: out_ready = (held > 10);
        endcase
        if (out_ready) have = 1'b0;
      end else begin
        out_ready = (ready_mode == 1) ? 1'($urandom_range(0, 1)) : (ready_mode == 0);
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    rst      = 1'b1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    in_cin   = 1'b0;
    in_sub   = 1'b0;

    @(negedge clk);
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", 64'(in_ready), 64'd1);

    // Directed cases with hand-derived results.
    ready_mode = 0;
    issue(64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, '{64'd0, 1'b1, 1'b0, 0});
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
          '{64'h8000_0000_0000_0000, 1'b0, 1'b1, 0});
    issue(64'd5, 64'd7, 1'b1, 1'b1, '{64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 0});
    issue(64'd7, 64'd5, 1'b0, 1'b1, '{64'd2, 1'b1, 1'b0, 0});
    drain();

    // Backpressure: result stalled 10 cycles, inputs wiggled during CALC.
    ready_mode = 2;
    issue(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0,
          '{64'h2222_2222_2222_2212, 1'b0, 1'b0, 0});
    repeat (3) begin
      @(negedge clk);
      in_a = {32'($urandom), 32'($urandom)};
      in_b = {32'($urandom), 32'($urandom)};
    end
    drain();

    // Reset during CALC aborts the operation.
    ready_mode = 0;
    issue(64'd10, 64'd20, 1'b0, 1'b0, '{64'd30, 1'b0, 1'b0, 0});
    @(negedge clk);
    rst = 1'b1;
    void'(sb.pop_back());
    n_issued--;
    @(negedge clk);
    chk("in_ready_during_rst", 64'(in_ready), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("in_ready_after_rst", 64'(in_ready), 64'd1);
    repeat (6) begin
      chk("no_out_after_abort", 64'(out_valid), 64'd0);
      @(negedge clk);
    end
    issue(64'd3, 64'd4, 1'b0, 1'b0, '{64'd7, 1'b0, 1'b0, 0});
    drain();

    // Unthrottled back-to-back: issue interval must be exactly 6.
    ready_mode   = 0;
    chk_interval = 1'b1;
    last_acc     = -1;
    for (int i = 0; i < 20; i++) rand_issue();
    chk_interval = 1'b0;
    drain();

    // Random traffic with random gaps and random out_ready.
    ready_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rand_issue();
    end
    drain();

    chk("received_vs_issued", 64'(n_recv), 64'(n_issued));
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
